// File: rtl/seven_segment_to_bcd_scanner.sv
// Samples a multiplexed active-low 7-segment bus, debounces each strobed digit,
// decodes it back to BCD and presents complete frames over valid/ready.
module seven_segment_to_bcd_scanner #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  input  logic                    frame_ready,
  output logic                    frame_valid,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    frame_err,
  output logic                    sel_err,
  output logic                    frame_drop
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_STABLE = 2'd0,
    CAPTURE     = 2'd1,
    HOLD        = 2'd2
  } state_t;

  function automatic logic [3:0] decode_seg(input logic [6:0] s);
    logic [3:0] code;
    case (s)
      7'b0000001: code = 4'd0;
      7'b1001111: code = 4'd1;
      7'b0010010: code = 4'd2;
      7'b0000110: code = 4'd3;
      7'b1001100: code = 4'd4;
      7'b0100100: code = 4'd5;
      7'b0100000: code = 4'd6;
      7'b0001111: code = 4'd7;
      7'b0000000: code = 4'd8;
      7'b0000100: code = 4'd9;
      7'b1111111: code = 4'hE;
      default:    code = 4'hF;
    endcase
    return code;
  endfunction

  logic [6:0]              seg_m, seg_q, seg_p;
  logic [NUM_DIGITS-1:0]   sel_m, sel_q, sel_p;
  logic [CW-1:0]           stab_cnt;
  state_t                  state, state_next;
  logic [NUM_DIGITS-1:0]   mask;
  logic [4*NUM_DIGITS-1:0] dig_buf;
  logic                    changed, cap, one_hot, multi, mask_full, buf_err;

  assign changed   = (seg_q != seg_p) || (sel_q != sel_p);
  assign cap       = (state == CAPTURE);
  // seg_p/sel_p hold the value that was stable on entry to CAPTURE
  assign one_hot   = (sel_p != '0) && ((sel_p & (sel_p - NUM_DIGITS'(1))) == '0);
  assign multi     = (sel_p != '0) && !one_hot;
  assign mask_full = &mask;

  always_comb begin
    buf_err = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig_buf[4*i +: 4] == 4'hF) begin
        buf_err = 1'b1;
      end else begin
        buf_err = buf_err;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_m <= '0; seg_q <= '0; seg_p <= '0;
      sel_m <= '0; sel_q <= '0; sel_p <= '0;
    end else begin
      seg_m <= seg;   seg_q <= seg_m;   seg_p <= seg_q;
      sel_m <= dig_sel; sel_q <= sel_m; sel_p <= sel_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stab_cnt <= '0;
    end else if (changed) begin
      stab_cnt <= '0;
    end else if (stab_cnt != CNT_MAX) begin
      stab_cnt <= stab_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= WAIT_STABLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      WAIT_STABLE: begin
        if (stab_cnt == CNT_MAX && !changed) state_next = CAPTURE;
        else                                  state_next = WAIT_STABLE;
      end
      CAPTURE: begin
        if (changed) state_next = WAIT_STABLE;
        else         state_next = HOLD;
      end
      HOLD: begin
        if (changed) state_next = WAIT_STABLE;
        else         state_next = HOLD;
      end
      default: state_next = WAIT_STABLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask    <= '0;
      dig_buf <= '0;
    end else if (mask_full) begin
      mask <= '0;
    end else if (cap && one_hot) begin
      mask <= mask | sel_p;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (sel_p[k]) dig_buf[4*k +: 4] <= decode_seg(seg_p);
      end
    end
  end

  // Output register: a completed frame loads only when the slot is free or draining
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_valid <= 1'b0;
      digits      <= '0;
      frame_err   <= 1'b0;
      sel_err     <= 1'b0;
      frame_drop  <= 1'b0;
    end else begin
      sel_err    <= cap && multi;
      frame_drop <= 1'b0;
      if (mask_full && (!frame_valid || frame_ready)) begin
        frame_valid <= 1'b1;
        digits      <= dig_buf;
        frame_err   <= buf_err;
      end else if (mask_full) begin
        frame_drop  <= 1'b1;
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_to_bcd_scanner.sv
// Bench for seven_segment_to_bcd_scanner: directed scenarios followed by random
// strobes, checked against a frame-level model of captured digit slots.
module tb_seven_segment_to_bcd_scanner;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [6:0]     seg;
  logic [N-1:0]   dig_sel;
  logic           frame_ready;
  logic           frame_valid;
  logic [4*N-1:0] digits;
  logic           frame_err;
  logic           sel_err;
  logic           frame_drop;

  seven_segment_to_bcd_scanner #(.NUM_DIGITS(N), .STABLE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .seg(seg), .dig_sel(dig_sel), .frame_ready(frame_ready),
    .frame_valid(frame_valid), .digits(digits), .frame_err(frame_err),
    .sel_err(sel_err), .frame_drop(frame_drop)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [6:0] pat [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                           7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  function automatic logic [3:0] ref_code(input logic [6:0] s);
    for (int i = 0; i < 10; i++) if (s == pat[i]) return 4'(i);
    if (s == 7'h7F) return 4'hE;
    return 4'hF;
  endfunction

  // Monitor: transfers and pulses observed away from the active edge
  logic [16:0] obs_q[$];
  int n_sel_err = 0;
  int n_drop = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_valid && frame_ready) obs_q.push_back({frame_err, digits});
      if (sel_err) n_sel_err++;
      if (frame_drop) n_drop++;
    end
  end

  // Model state
  logic [3:0]  m_slot [N];
  logic [N-1:0] m_mask;
  bit          m_full;
  logic [16:0] m_held;
  logic [16:0] exp_q[$];
  int exp_sel = 0;
  int exp_drop = 0;

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_slot[i] = 4'h0;
    m_mask = '0;
    m_full = 1'b0;
    m_held = '0;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic model_step(input logic [6:0] s, input logic [N-1:0] sel, input bit rdy);
    logic [16:0] fr;
    bit any_f;
    int k;
    if (m_full && rdy) begin
      exp_q.push_back(m_held);
      m_full = 1'b0;
    end
    if ($countones(sel) == 1) begin
      k = 0;
      for (int i = 0; i < N; i++) if (sel[i]) k = i;
      m_slot[k] = ref_code(s);
      m_mask[k] = 1'b1;
      if (&m_mask) begin
        any_f = 1'b0;
        fr = '0;
        for (int i = 0; i < N; i++) begin
          fr[4*i +: 4] = m_slot[i];
          if (m_slot[i] == 4'hF) any_f = 1'b1;
        end
        fr[16] = any_f;
        m_mask = '0;
        if (m_full) begin
          exp_drop++;
        end else if (rdy) begin
          exp_q.push_back(fr);
        end else begin
          m_full = 1'b1;
          m_held = fr;
        end
      end
    end else if ($countones(sel) > 1) begin
      exp_sel++;
    end
  endtask

  task automatic drive_step(input logic [6:0] s, input logic [N-1:0] sel, input bit rdy,
                            input bit glitch);
    model_step(s, sel, rdy);
    @(posedge clk); #1;
    frame_ready = rdy;
    dig_sel = sel;
    if (glitch) begin
      seg = s ^ 7'h2A;
      repeat (2) @(posedge clk);
      #1;
    end
    seg = s;
    repeat (12) @(posedge clk);
    #1;
    seg = 7'h7F;
    dig_sel = '0;
    repeat (8) @(posedge clk);
  endtask

  task automatic compare_state(input string tag);
    logic [16:0] o, e;
    @(negedge clk);
    check_eq({tag, ".n_acc"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check_eq({tag, ".frame"}, 32'(o), 32'(e));
    end
    obs_q.delete();
    exp_q.delete();
    check_eq({tag, ".sel_err"}, n_sel_err, exp_sel);
    check_eq({tag, ".drop"}, n_drop, exp_drop);
    check_eq({tag, ".valid"}, frame_valid, m_full);
    if (m_full) check_eq({tag, ".held"}, {frame_err, digits}, m_held);
  endtask

  task automatic step(input string tag, input logic [6:0] s, input logic [N-1:0] sel,
                      input bit rdy, input bit glitch);
    drive_step(s, sel, rdy, glitch);
    compare_state(tag);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, ".valid0"}, frame_valid, 1'b0);
    check_eq({tag, ".digits0"}, digits, '0);
    check_eq({tag, ".err0"}, frame_err, 1'b0);
    check_eq({tag, ".sel_err0"}, sel_err, 1'b0);
    check_eq({tag, ".drop0"}, frame_drop, 1'b0);
  endtask

  initial begin
    logic [6:0]   rs;
    logic [N-1:0] rsel;
    int a, b;
    rst = 1'b1;
    seg = 7'h7F;
    dig_sel = '0;
    frame_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // 1: digits 1,2,3,4 into slots 0..3
    step("t1d0", pat[1], 4'b0001, 1'b1, 1'b0);
    step("t1d1", pat[2], 4'b0010, 1'b1, 1'b0);
    step("t1d2", pat[3], 4'b0100, 1'b1, 1'b0);
    drive_step(pat[4], 4'b1000, 1'b1, 1'b0);
    check_eq("t1.expect4321", 32'(exp_q.size() == 1 ? exp_q[0] : 17'h1FFFF), 32'h04321);
    compare_state("t1d3");

    // 2: glitch on digit 1 must not be captured
    step("t2d0", pat[5], 4'b0001, 1'b1, 1'b0);
    step("t2d1", pat[7], 4'b0010, 1'b1, 1'b1);
    step("t2d2", pat[8], 4'b0100, 1'b1, 1'b0);
    step("t2d3", pat[9], 4'b1000, 1'b1, 1'b0);

    // 3: invalid pattern gives F and frame_err; blank gives E without error
    step("t3a0", pat[0], 4'b0001, 1'b1, 1'b0);
    step("t3a1", pat[6], 4'b0010, 1'b1, 1'b0);
    step("t3a2", 7'b1010101, 4'b0100, 1'b1, 1'b0);
    step("t3a3", pat[2], 4'b1000, 1'b1, 1'b0);
    step("t3b2", 7'h7F, 4'b0100, 1'b1, 1'b0);
    step("t3b0", pat[3], 4'b0001, 1'b1, 1'b0);
    step("t3b1", pat[3], 4'b0010, 1'b1, 1'b0);
    step("t3b3", pat[3], 4'b1000, 1'b1, 1'b0);

    // 4: multiple strobes set
    step("t4", pat[1], 4'b0110, 1'b1, 1'b0);

    // 5: backpressure, second frame dropped, then released
    for (int f = 0; f < 2; f++)
      for (int d = 0; d < N; d++)
        step("t5", pat[(f * 4 + d) % 10], 4'(1 << d), 1'b0, 1'b0);
    step("t5rel", pat[0], 4'b0000, 1'b1, 1'b0);

    // 6: reset with a frame held and two digits partially captured
    for (int d = 0; d < N; d++) step("t6pre", pat[d + 2], 4'(1 << d), 1'b0, 1'b0);
    step("t6p0", pat[7], 4'b0001, 1'b0, 1'b0);
    step("t6p1", pat[8], 4'b0010, 1'b0, 1'b0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check_outputs_zero("t6rst");
    model_reset();
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    step("t6n2", pat[1], 4'b0100, 1'b1, 1'b0);
    step("t6n3", pat[2], 4'b1000, 1'b1, 1'b0);
    step("t6n0", pat[3], 4'b0001, 1'b1, 1'b0);
    step("t6n1", pat[4], 4'b0010, 1'b1, 1'b0);

    // Random strobes
    for (int i = 0; i < 70; i++) begin
      a = $urandom_range(7);
      if (a <= 5) begin
        rsel = 4'(1 << $urandom_range(N - 1));
      end else if (a == 6) begin
        rsel = '0;
      end else begin
        a = $urandom_range(N - 1);
        b = (a + 1 + $urandom_range(N - 2)) % N;
        rsel = 4'((1 << a) | (1 << b));
      end
      a = $urandom_range(5);
      if (a <= 3)      rs = pat[$urandom_range(9)];
      else if (a == 4) rs = 7'h7F;
      else             rs = 7'($urandom);
      step("rnd", rs, rsel, 1'($urandom_range(2) != 0), $urandom_range(3) == 0);
    end
    step("final", pat[0], 4'b0000, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
